// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
//
// Owns the single port of the instruction memory and shares it between the
// fetch stage and a program-load stream. In RUN the fetch stage reads the
// memory directly with zero latency. On load_start the core is stalled, the
// incoming stream is written into the memory from address 0, the written words
// are read back and their checksum compared against the stream checksum, and
// the core is restarted at PC 0.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   load_start    one-cycle load request, honoured only in RUN
//   in_valid      load stream beat valid
//   in_data       load stream word
//   in_last       final word of the stream (qualified by in_valid)
//   in_ready      controller consumes a stream beat this cycle
//   fetch_addr    word address from the IF-stage PC
//   fetch_data    instruction returned to IF (NOP_WORD while stalled)
//   cpu_stall     holds PC and pipeline registers
//   pc_clear      one-cycle pulse forcing the PC to 0
//   mem_addr      memory word address (controller is the sole driver)
//   mem_wdata     memory write data
//   mem_we        memory write enable, write lands at the clk edge
//   mem_rdata     combinational memory read data for mem_addr
//   load_done     one-cycle pulse when a load finishes
//   load_err      sticky checksum-mismatch / overflow flag
//   word_count    number of words written by the last load
// -----------------------------------------------------------------------------
module imem_load_ctrl #(
    parameter int unsigned       ADDR_W   = 6,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    // load stream
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    // fetch stage
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              cpu_stall,
    output logic              pc_clear,
    // instruction memory port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LastAddr = '1;
    localparam logic [ADDR_W-1:0] PtrOne   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CntOne   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StRun,
        StLoad,
        StVerify,
        StFinish
    } state_e;

    state_e              r_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [DATA_W-1:0]   r_sum_in;
    logic [DATA_W-1:0]   r_sum_rd;
    logic [ADDR_W:0]     r_word_count;
    logic                r_load_err;
    logic                r_load_done;
    logic                r_pc_clear;

    logic                w_at_end;
    logic                w_verify_last;
    logic [DATA_W-1:0]   w_sum_rd_next;

    // The last writable address forces the end of the stream.
    assign w_at_end      = (r_wr_ptr == LastAddr);
    // VERIFY runs for exactly word_count cycles; word_count is never 0 here.
    assign w_verify_last = ({1'b0, r_rd_ptr} == (r_word_count - CntOne));
    // Include the word read this cycle so the compare can be registered on
    // the edge into FINISH and be visible during FINISH.
    assign w_sum_rd_next = r_sum_rd + mem_rdata;

    // -------------------------------------------------------------------------
    // Control FSM with registered status outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StRun;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_sum_in     <= '0;
            r_sum_rd     <= '0;
            r_word_count <= '0;
            r_load_err   <= 1'b0;
            r_load_done  <= 1'b0;
            r_pc_clear   <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_pc_clear  <= 1'b0;
            unique case (r_state)
                StRun: begin
                    if (load_start) begin
                        r_state      <= StLoad;
                        r_load_err   <= 1'b0;
                        r_wr_ptr     <= '0;
                        r_rd_ptr     <= '0;
                        r_sum_in     <= '0;
                        r_sum_rd     <= '0;
                        r_word_count <= '0;
                    end
                end
                StLoad: begin
                    // in_last is only meaningful together with in_valid.
                    if (in_valid) begin
                        r_sum_in <= r_sum_in + in_data;
                        r_wr_ptr <= r_wr_ptr + PtrOne;
                        if (in_last || w_at_end) begin
                            r_state      <= StVerify;
                            r_word_count <= {1'b0, r_wr_ptr} + CntOne;
                            // Memory full but the stream claims more words.
                            if (w_at_end && !in_last) begin
                                r_load_err <= 1'b1;
                            end
                        end
                    end
                end
                StVerify: begin
                    r_sum_rd <= w_sum_rd_next;
                    r_rd_ptr <= r_rd_ptr + PtrOne;
                    if (w_verify_last) begin
                        r_state     <= StFinish;
                        r_rd_ptr    <= '0;
                        r_load_done <= 1'b1;
                        r_pc_clear  <= 1'b1;
                        if (w_sum_rd_next != r_sum_in) begin
                            r_load_err <= 1'b1;
                        end
                    end
                end
                StFinish: begin
                    r_state <= StRun;
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memory port steering and fetch/stall outputs, decoded from the state
    // -------------------------------------------------------------------------
    always_comb begin
        mem_addr   = fetch_addr;
        mem_wdata  = in_data;
        mem_we     = 1'b0;
        fetch_data = NOP_WORD;
        cpu_stall  = 1'b1;
        in_ready   = 1'b0;
        unique case (r_state)
            StRun: begin
                fetch_data = mem_rdata;
                cpu_stall  = 1'b0;
            end
            StLoad: begin
                mem_addr = r_wr_ptr;
                in_ready = 1'b1;
                mem_we   = in_valid;
            end
            StVerify: begin
                mem_addr = r_rd_ptr;
            end
            StFinish: begin
                mem_addr = r_rd_ptr;
            end
            default: begin
                mem_addr = fetch_addr;
            end
        endcase
    end

    assign load_done  = r_load_done;
    assign pc_clear   = r_pc_clear;
    assign load_err   = r_load_err;
    assign word_count = r_word_count;

    // -------------------------------------------------------------------------
    // Invariants of the port arbitration
    // -------------------------------------------------------------------------
    a_we_only_in_load : assert property (
        @(posedge clk) disable iff (rst) mem_we |-> (r_state == StLoad));

    a_ready_only_in_load : assert property (
        @(posedge clk) disable iff (rst) in_ready |-> (r_state == StLoad));

    a_verify_count_nonzero : assert property (
        @(posedge clk) disable iff (rst) (r_state == StVerify) |-> (r_word_count != '0));

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

    localparam int          AW  = 6;
    localparam int          DW  = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [AW-1:0] fetch_addr = '0;
    logic [DW-1:0] fetch_data;
    logic          cpu_stall;
    logic          pc_clear;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_count;

    imem_load_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .NOP_WORD(NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .fetch_addr(fetch_addr),
        .fetch_data(fetch_data),
        .cpu_stall (cpu_stall),
        .pc_clear  (pc_clear),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .load_done (load_done),
        .load_err  (load_err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write at the clock edge. The corrupt
    // flag flips bit 0 of address 2 on stalled reads (VERIFY read-back).
    logic [DW-1:0] tmem [64];
    bit            corrupt = 1'b0;
    always @(posedge clk) if (mem_we) tmem[mem_addr] <= mem_wdata;
    assign mem_rdata = tmem[mem_addr] ^
        {{(DW-1){1'b0}}, (corrupt && cpu_stall && !mem_we && mem_addr == 6'd2)};

    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected memory writes, pushed when a beat is driven.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t sb_q[$];

    always @(negedge clk) begin
        if (!rst && mem_we) begin
            wr_t e;
            n_writes++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d data 0x%h, no write expected",
                         mem_addr, mem_wdata);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    // RUN-mode fetch vectors.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          stall;
        logic          ready;
    } fvec_t;

    fvec_t run_tab[4];
    fvec_t post_tab[4];

    logic [DW-1:0] prog [4];
    logic [DW-1:0] stim [70];

    task automatic apply_fetch(input fvec_t v, input string tag);
        @(posedge clk);
        #1 fetch_addr = v.addr;
        @(negedge clk);
        check({tag, "_fetch_data"}, 64'(fetch_data), 64'(v.data));
        check({tag, "_stall"}, 64'(cpu_stall), 64'(v.stall));
        check({tag, "_ready"}, 64'(in_ready), 64'(v.ready));
    endtask

    // Drives a complete load of stim[0..n-1]; returns the cycle (load_start
    // cycle = 1) in which load_done was seen and the number of LOAD cycles.
    task automatic run_load(input int n, input bit gaps, input bit mark_last,
                            output int done_rel, output int load_cyc);
        int c0;
        @(posedge clk);
        #1;
        c0         = cyc;
        load_start = 1'b1;
        // A beat coinciding with load_start must not be consumed.
        in_valid   = 1'b1;
        in_data    = 32'hDEADBEEF;
        in_last    = 1'b0;
        @(negedge clk);
        check("ready_in_run", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        load_cyc   = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
                if (in_ready) load_cyc++;
                check("nop_fetch_gap", 64'(fetch_data), 64'(NOP));
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            in_last  = mark_last && (i == n - 1);
            if (i < 64) sb_q.push_back('{addr: AW'(i), data: stim[i]});
            @(negedge clk);
            if (i == 0) check("err_cleared", 64'(load_err), 64'd0);
            if (i >= 64) check("ready_after_overflow", 64'(in_ready), 64'd0);
            else if (in_ready) load_cyc++;
            check("nop_fetch", 64'(fetch_data), 64'(NOP));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        done_rel = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (load_done) begin
                done_rel = cyc - c0 + 1;
                break;
            end
        end
        if (done_rel < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: load_done never seen, required within 300 cycles");
        end else begin
            check("pc_clear_with_done", 64'(pc_clear), 64'd1);
            check("stall_in_finish", 64'(cpu_stall), 64'd1);
            @(negedge clk);
            check("stall_released", 64'(cpu_stall), 64'd0);
            check("done_single_pulse", 64'(load_done), 64'd0);
            check("pc_clear_single_pulse", 64'(pc_clear), 64'd0);
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int done_rel;
        int load_cyc;
        int w0;

        for (int i = 0; i < 64; i++) tmem[i] = 32'hC0DE0000 | 32'(i);
        prog[0] = 32'h00100093;
        prog[1] = 32'h00200113;
        prog[2] = 32'h002081B3;
        prog[3] = 32'h00000013;

        run_tab[0] = '{addr: 6'd5,  data: 32'hC0DE0005, stall: 1'b0, ready: 1'b0};
        run_tab[1] = '{addr: 6'd0,  data: 32'hC0DE0000, stall: 1'b0, ready: 1'b0};
        run_tab[2] = '{addr: 6'd63, data: 32'hC0DE003F, stall: 1'b0, ready: 1'b0};
        run_tab[3] = '{addr: 6'd31, data: 32'hC0DE001F, stall: 1'b0, ready: 1'b0};
        for (int i = 0; i < 4; i++) begin
            post_tab[i] = '{addr: AW'(i), data: prog[i], stall: 1'b0, ready: 1'b0};
        end

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 64'(cpu_stall), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_pc_clear", 64'(pc_clear), 64'd0);
        check("rst_err", 64'(load_err), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        rst = 1'b0;

        // Direct fetch in RUN.
        for (int i = 0; i < 4; i++) apply_fetch(run_tab[i], "run");

        // Back-to-back 4-word load.
        for (int i = 0; i < 4; i++) stim[i] = prog[i];
        w0 = n_writes;
        run_load(4, 1'b0, 1'b1, done_rel, load_cyc);
        check("b2b_done_cycle", 64'(done_rel), 64'd10);
        check("b2b_load_cycles", 64'(load_cyc), 64'd4);
        check("b2b_writes", 64'(n_writes - w0), 64'd4);
        check("b2b_word_count", 64'(word_count), 64'd4);
        check("b2b_err", 64'(load_err), 64'd0);
        for (int i = 0; i < 4; i++) apply_fetch(post_tab[i], "post");

        // Same load with a bubble between beats.
        w0 = n_writes;
        run_load(4, 1'b1, 1'b1, done_rel, load_cyc);
        check("gap_done_cycle", 64'(done_rel), 64'd13);
        check("gap_load_cycles", 64'(load_cyc), 64'd7);
        check("gap_writes", 64'(n_writes - w0), 64'd4);
        check("gap_word_count", 64'(word_count), 64'd4);
        check("gap_err", 64'(load_err), 64'd0);
        for (int i = 0; i < 4; i++) check("gap_mem", 64'(tmem[i]), 64'(prog[i]));

        // Overflow: 70 beats, none marked last.
        for (int i = 0; i < 70; i++) stim[i] = 32'h10000000 + 32'(i * 3);
        w0 = n_writes;
        run_load(70, 1'b0, 1'b0, done_rel, load_cyc);
        check("ovf_done_cycle", 64'(done_rel), 64'd130);
        check("ovf_load_cycles", 64'(load_cyc), 64'd64);
        check("ovf_writes", 64'(n_writes - w0), 64'd64);
        check("ovf_word_count", 64'(word_count), 64'd64);
        check("ovf_err", 64'(load_err), 64'd1);
        check("ovf_mem63", 64'(tmem[63]), 64'(32'h10000000 + 32'd189));

        // Corrupted read-back, then a clean load clears the flag.
        for (int i = 0; i < 4; i++) stim[i] = prog[i];
        corrupt = 1'b1;
        run_load(4, 1'b0, 1'b1, done_rel, load_cyc);
        check("bad_sum_err", 64'(load_err), 64'd1);
        check("bad_sum_word_count", 64'(word_count), 64'd4);
        corrupt = 1'b0;
        run_load(4, 1'b0, 1'b1, done_rel, load_cyc);
        check("clean_err", 64'(load_err), 64'd0);

        // Reset on the third LOAD beat.
        @(posedge clk);
        #1 load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hAAAA0000 + 32'(i);
            if (i < 2) begin
                sb_q.push_back('{addr: AW'(i), data: in_data});
                @(posedge clk);
                #1;
            end
        end
        #2 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_stall", 64'(cpu_stall), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_we", 64'(mem_we), 64'd0);
        check("mid_rst_word_count", 64'(word_count), 64'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        check("mid_rst_mem0", 64'(tmem[0]), 64'(32'hAAAA0000));
        check("mid_rst_mem1", 64'(tmem[1]), 64'(32'hAAAA0001));
        check("mid_rst_mem2", 64'(tmem[2]), 64'(prog[2]));
        apply_fetch('{addr: 6'd1, data: 32'hAAAA0001, stall: 1'b0, ready: 1'b0}, "after_rst");
        check("mid_rst_scoreboard", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Controller that owns the single port of the 64-word instruction memory and shares it between the fetch stage and a program-load stream.
- In RUN, the fetch stage reads the memory directly.
- On request, the controller stalls the core, streams new words into the memory and reads them back to verify a checksum. It then restarts the core at PC 0.
- It sits between IF-stage PC logic, the load interface and the instruction memory array.

Parameters:
- ADDR_W, 6, word-address width; memory depth is 2^ADDR_W.
- DATA_W, 32, instruction width.
- NOP_WORD, 32'h00000013, word presented to fetch while the core is stalled (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle request to begin a program load; honoured only in RUN.
- in_valid  in  1  load stream word valid.
- in_data  in  DATA_W  load stream word.
- in_last  in  1  marks the final word of the stream; qualified by in_valid.
- in_ready  out  1  controller accepts a stream word this cycle.
- fetch_addr  in  ADDR_W  word address from the PC (PC[7:2]).
- fetch_data  out  DATA_W  instruction returned to IF.
- cpu_stall  out  1  holds PC and pipeline registers.
- pc_clear  out  1  one-cycle pulse forcing the PC to 0.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable; the write takes effect at the clk edge.
- mem_rdata  in  DATA_W  memory combinational read data for mem_addr.
- load_done  out  1  one-cycle pulse when a load finishes.
- load_err  out  1  sticky; set if the verify checksum mismatched or the stream overflowed; cleared by the next load_start.
- word_count  out  ADDR_W+1  number of words written by the last load.

Behaviour:
- States: RUN, LOAD, VERIFY, FINISH.
- Reset (async) values:
  - state = RUN; wr_ptr = rd_ptr = 0; sum_in = sum_rd = 0.
  - word_count = 0; load_err = 0; load_done = 0; pc_clear = 0.
  - Memory contents are untouched by reset; a partial load is left in place.
- RUN:
  - mem_addr = fetch_addr, fetch_data = mem_rdata (zero latency); cpu_stall = 0, in_ready = 0, mem_we = 0.
  - load_start = 1 moves to LOAD next cycle; it clears load_err, wr_ptr, sum_in and word_count.
  - A stream beat arriving in the same cycle as load_start is not accepted.
- LOAD:
  - cpu_stall = 1, fetch_data = NOP_WORD, in_ready = 1.
  - On in_valid (combinationally within the cycle): mem_we = 1, mem_addr = wr_ptr, mem_wdata = in_data.
  - At the clock edge: sum_in += in_data (mod 2^32) and wr_ptr increments.
  - If in_last is set, or wr_ptr == 2^ADDR_W-1, go to VERIFY; word_count = wr_ptr+1.
  - If wr_ptr == 2^ADDR_W-1 and in_last = 0, set load_err (overflow). Later beats see in_ready = 0 and are not consumed.
  - in_valid = 0 holds the state indefinitely; in_last without in_valid is ignored.
  - load_start in LOAD is ignored.
- VERIFY:
  - cpu_stall = 1, in_ready = 0, mem_we = 0, mem_addr = rd_ptr.
  - Each cycle: sum_rd += mem_rdata and rd_ptr increments.
  - Leave after exactly word_count cycles; rd_ptr resets to 0.
- FINISH (1 cycle):
  - cpu_stall = 1.
  - load_done = 1 and pc_clear = 1 for this cycle only.
  - load_err |= (sum_rd != sum_in).
  - Next state RUN; cpu_stall drops the following cycle.
- Latency for an N-word load with no bubbles: N LOAD cycles + N VERIFY cycles + 1 FINISH cycle. The first new instruction is fetched at PC 0 in the first RUN cycle.
- Memory write and combinational read never occur in the same cycle from different owners; the controller is the sole driver of mem_addr.
- Reset asserted mid-LOAD/VERIFY: the controller returns immediately to RUN with the stall released; word_count = 0.

Test Plan:
- Reset, no load: fetch_addr = 5 -> fetch_data = mem[5] the same cycle, cpu_stall = 0, in_ready = 0.
- Load 4 words 0x00100093, 0x00200113, 0x002081B3, 0x00000013 (last on beat 4), back-to-back -> mem_we high for 4 cycles at addr 0..3, then 4 VERIFY cycles. load_done and pc_clear pulse in cycle 10 after load_start, load_err = 0, word_count = 4, cpu_stall low in cycle 11.
- Same load with in_valid low every other cycle -> identical memory contents and word_count = 4; LOAD lasts 7 cycles; fetch_data = 0x00000013 throughout.
- Stream 70 words, none marked last -> 64 words written, word_count = 64, load_err = 1, in_ready = 0 after beat 64, load_done pulses.
- Force mem_rdata bit 0 flipped at addr 2 during VERIFY -> load_err = 1 at FINISH; clear via a new load_start -> load_err = 0.
- rst pulsed on the third LOAD beat -> state RUN, cpu_stall = 0 within the same cycle, word_count = 0, words 0..1 retained in memory.
